// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master arbiter for the shared SoC memory-mapped bus.
// Grants one transaction at a time, drives bus_we/bus_addr/bus_wdata, times the
// read return (RD_LAT cycles after the address) and pulses the winner's ack.
// Optional build macro: ARB_FIXED_PRIO_EN -- m0 always wins a tie (m1 may starve).
// Default build (macro undefined): round robin on a tie, last_gnt resets to m1.
module soc_bus_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1   // legal range 1..15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // master 0
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_rdata_o,
  // master 1
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_rdata_o,
  // shared bus towards the address decoder
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic [DW-1:0] bus_rdata_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  localparam logic [3:0] LatLoad = 4'(RD_LAT - 1);

  state_e        state_q;
  logic [1:0]    gnt_q;
  logic          last_gnt_q;  // 1 = m1 was granted last
  logic          bus_we_q;
  logic [AW-1:0] bus_addr_q;
  logic [DW-1:0] bus_wdata_q;
  logic          m0_ack_q;
  logic          m1_ack_q;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;
  logic [3:0]    cnt_q;

  logic          any_req;
  logic          win_m1;

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    any_req = m0_req_i | m1_req_i;
    win_m1  = m1_req_i;
    if (m0_req_i && m1_req_i) begin
`ifdef ARB_FIXED_PRIO_EN
      win_m1 = 1'b0;
`else
      win_m1 = ~last_gnt_q;
`endif
    end
  end

  // Transaction FSM; every bus and master-facing output is registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      last_gnt_q  <= 1'b1;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          bus_we_q <= 1'b0;
          gnt_q    <= 2'b00;
          if (any_req) begin
            last_gnt_q  <= win_m1;
            gnt_q       <= win_m1 ? 2'b10 : 2'b01;
            bus_we_q    <= win_m1 ? m1_we_i : m0_we_i;
            bus_addr_q  <= win_m1 ? m1_addr_i : m0_addr_i;
            bus_wdata_q <= win_m1 ? m1_wdata_i : m0_wdata_i;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          // bus_we_q is high in ACCESS exactly when the transaction is a write.
          bus_we_q <= 1'b0;
          if (bus_we_q) begin
            m0_ack_q <= gnt_q[0];
            m1_ack_q <= gnt_q[1];
            state_q  <= StDone;
          end else begin
            cnt_q   <= LatLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            if (gnt_q[0]) m0_rdata_q <= bus_rdata_i;
            if (gnt_q[1]) m1_rdata_q <= bus_rdata_i;
            m0_ack_q <= gnt_q[0];
            m1_ack_q <= gnt_q[1];
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          gnt_q    <= 2'b00;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign gnt_o       = gnt_q;

endmodule
